// File: rtl/seq_magnitude_comparator_if.sv
// Operand/result bundle for seq_magnitude_comparator: the requester drives start/a/b/signed_mode.
// The comparator returns busy, a done pulse and registered eq/lt/gt flags.
interface seq_magnitude_comparator_if #(
  parameter int WIDTH = 16
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             signed_mode;
  logic             busy;
  logic             done;
  logic             eq;
  logic             lt;
  logic             gt;

  modport master (
    output start, a, b, signed_mode,
    input  busy, done, eq, lt, gt
  );

  modport slave (
    input  start, a, b, signed_mode,
    output busy, done, eq, lt, gt
  );
endinterface

// File: rtl/seq_magnitude_comparator.sv
// MSB-first chunked magnitude compare. Latency is 1..NCH edges, or always NCH with SEQ_CMP_FIXED_LATENCY_EN.
// start is honoured only while idle; requests made while busy are dropped, and results hold until the next done.
module seq_magnitude_comparator #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input logic                   clk,
  input logic                   rst,
  seq_magnitude_comparator_if.slave cmp
);

  localparam int NCH = WIDTH / ((CHUNK > 0) ? CHUNK : 1);
  localparam int IW  = (NCH > 1) ? $clog2(NCH) : 1;
  localparam logic [IW-1:0] TOP = IW'(NCH - 1);

  generate
    if ((CHUNK < 1) || (CHUNK > WIDTH) || ((WIDTH % CHUNK) != 0)) begin : g_param_check
      $error("seq_magnitude_comparator: WIDTH must be a positive multiple of CHUNK");
    end
  endgenerate

  typedef enum logic {IDLE, CMP} state_t;

  state_t           state;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic             sgn_q;
  logic [IW-1:0]    idx;
  logic             busy_q;
  logic             done_q;
  logic             eq_q;
  logic             lt_q;
  logic             gt_q;

  logic [CHUNK-1:0] ch_a;
  logic [CHUNK-1:0] ch_b;
  logic             c_lt;
  logic             c_gt;

  // Flipping both sign bits maps two's-complement order onto unsigned order for the top chunk.
  always_comb begin
    ch_a = a_q[idx*CHUNK +: CHUNK];
    ch_b = b_q[idx*CHUNK +: CHUNK];
    if (sgn_q && (idx == TOP)) begin
      ch_a[CHUNK-1] = ~ch_a[CHUNK-1];
      ch_b[CHUNK-1] = ~ch_b[CHUNK-1];
    end
    c_lt = (ch_a < ch_b);
    c_gt = (ch_a > ch_b);
  end

`ifdef SEQ_CMP_FIXED_LATENCY_EN
  logic dec_set;
  logic dec_lt;
  logic dec_gt;
  logic res_lt;
  logic res_gt;

  // The first differing chunk wins; later chunks are scanned only to keep timing constant.
  always_comb begin
    res_lt = dec_set ? dec_lt : c_lt;
    res_gt = dec_set ? dec_gt : c_gt;
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      a_q    <= '0;
      b_q    <= '0;
      sgn_q  <= 1'b0;
      idx    <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      eq_q   <= 1'b0;
      lt_q   <= 1'b0;
      gt_q   <= 1'b0;
`ifdef SEQ_CMP_FIXED_LATENCY_EN
      dec_set <= 1'b0;
      dec_lt  <= 1'b0;
      dec_gt  <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (cmp.start) begin
            a_q    <= cmp.a;
            b_q    <= cmp.b;
            sgn_q  <= cmp.signed_mode;
            idx    <= TOP;
            busy_q <= 1'b1;
            state  <= CMP;
`ifdef SEQ_CMP_FIXED_LATENCY_EN
            dec_set <= 1'b0;
            dec_lt  <= 1'b0;
            dec_gt  <= 1'b0;
`endif
          end
        end
        CMP: begin
`ifdef SEQ_CMP_FIXED_LATENCY_EN
          if (!dec_set && (c_lt || c_gt)) begin
            dec_set <= 1'b1;
            dec_lt  <= c_lt;
            dec_gt  <= c_gt;
          end
          if (idx == '0) begin
            eq_q   <= ~(res_lt | res_gt);
            lt_q   <= res_lt;
            gt_q   <= res_gt;
            done_q <= 1'b1;
            busy_q <= 1'b0;
            state  <= IDLE;
          end else begin
            idx <= idx - IW'(1);
          end
`else
          if (c_lt || c_gt) begin
            eq_q   <= 1'b0;
            lt_q   <= c_lt;
            gt_q   <= c_gt;
            done_q <= 1'b1;
            busy_q <= 1'b0;
            state  <= IDLE;
          end else if (idx == '0) begin
            eq_q   <= 1'b1;
            lt_q   <= 1'b0;
            gt_q   <= 1'b0;
            done_q <= 1'b1;
            busy_q <= 1'b0;
            state  <= IDLE;
          end else begin
            idx <= idx - IW'(1);
          end
`endif
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign cmp.busy = busy_q;
  assign cmp.done = done_q;
  assign cmp.eq   = eq_q;
  assign cmp.lt   = lt_q;
  assign cmp.gt   = gt_q;

endmodule
